// File: rtl/frame_crc_checker.sv
// rtl/frame_crc_checker.sv - streams an SRAM frame region and folds it into a CRC-16/CCITT signature
module frame_crc_checker #(
    parameter logic [17:0] BASE_ADDR    = 18'd146944,
    parameter logic [17:0] NUM_WORDS    = 18'd115200,
    parameter int          READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic [17:0] word_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [17:0]             addr_q, addr_d;
    logic [17:0]             issue_cnt_q, issue_cnt_d;
    logic [17:0]             word_cnt_q, word_cnt_d;
    logic [15:0]             crc_q, crc_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic                    issue;
    logic                    absorb;

    // One CRC-16 step over a full word: poly 0x1021, bit 15 first, no reflection.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Read-valid shift register: a read issued now is absorbed READ_LATENCY cycles later.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Next-state, address sequencing and CRC absorb.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        word_cnt_d  = word_cnt_q;
        crc_d       = crc_q;
        issue       = 1'b0;
        absorb      = vld_q[READ_LATENCY-1];

        if (absorb) begin
            crc_d      = crc_step(crc_q, SRAM_read_data);
            word_cnt_d = word_cnt_q + 18'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ISSUE;
                    crc_d       = 16'hFFFF;
                    word_cnt_d  = 18'd0;
                    issue_cnt_d = 18'd0;
                    addr_d      = BASE_ADDR;
                end
            end
            S_ISSUE: begin
                issue       = 1'b1;
                issue_cnt_d = issue_cnt_q + 18'd1;
                // The last address stays on the bus through the drain phase.
                if (issue_cnt_q == NUM_WORDS - 18'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 18'd1;
                end
            end
            S_DRAIN: begin
                // Leave as the final word is absorbed so done lands on the next cycle.
                if (word_cnt_d == NUM_WORDS) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                addr_d  = BASE_ADDR;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset also drops any reads still in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            issue_cnt_q <= 18'd0;
            word_cnt_q  <= 18'd0;
            crc_q       <= 16'hFFFF;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            word_cnt_q  <= word_cnt_d;
            crc_q       <= crc_d;
            vld_q       <= vld_d;
        end
    end

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign checksum     = crc_q;
    assign word_count   = word_cnt_q;

endmodule

// File: tb/tb_frame_crc_checker.sv
// tb/tb_frame_crc_checker.sv - directed self-checking bench for frame_crc_checker
module tb_frame_crc_checker;

    localparam logic [17:0] A_BASE = 18'd146944;
    localparam logic [17:0] B_BASE = 18'h3FFFE;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        start_a, start_b;
    logic [15:0] seed;
    logic [17:0] addr_a, addr_b;
    logic        we_a, we_b;
    logic [15:0] rd_a, rd_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] cs_a, cs_b;
    logic [17:0] wc_a, wc_b;
    logic [17:0] pa [2];
    logic [17:0] pb [3];
    int          total = 0;
    int          bad = 0;

    always #5 Clock = ~Clock;

    frame_crc_checker #(.BASE_ADDR(A_BASE), .NUM_WORDS(18'd1), .READ_LATENCY(2)) dut_a (
        .Clock(Clock), .Reset(Reset), .start(start_a), .SRAM_address(addr_a),
        .SRAM_we_n(we_a), .SRAM_read_data(rd_a), .busy(busy_a), .done(done_a),
        .checksum(cs_a), .word_count(wc_a)
    );

    frame_crc_checker #(.BASE_ADDR(B_BASE), .NUM_WORDS(18'd4), .READ_LATENCY(3)) dut_b (
        .Clock(Clock), .Reset(Reset), .start(start_b), .SRAM_address(addr_b),
        .SRAM_we_n(we_b), .SRAM_read_data(rd_b), .busy(busy_b), .done(done_b),
        .checksum(cs_b), .word_count(wc_b)
    );

    function automatic logic [15:0] mem_word(input logic [17:0] a, input logic [15:0] s);
        logic [17:0] t;
        if (s == 16'h0000) return 16'h0000;
        t = a * 18'h09E37;
        return t[15:0] ^ s ^ {14'd0, t[17:16]};
    endfunction

    // Reference: xor word into register, then 16 plain shifts.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int i = 0; i < 16; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_b(input logic [15:0] s);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) c = crc_ref(c, mem_word(B_BASE + 18'(i), s));
        return c;
    endfunction

    // SRAM models: address pipeline of READ_LATENCY stages
    always @(posedge Clock) begin
        pa[0] <= addr_a;
        pa[1] <= pa[0];
        pb[0] <= addr_b;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    always_comb begin
        rd_a = mem_word(pa[1], seed);
        rd_b = mem_word(pb[2], seed);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_b(input int p1, input int p2, output logic [15:0] cs,
                         output int ndone, output int done_at, output int err);
        ndone   = 0;
        done_at = -1;
        err     = 0;
        @(negedge Clock);
        start_b = 1'b1;
        for (int m = 1; m <= 16; m++) begin
            @(negedge Clock);
            start_b = (m == p1) || (m == p2);
            if (m <= 4 && addr_b !== B_BASE + 18'(m - 1)) err++;
            if (we_b !== 1'b1) err++;
            if (m <= 7 && busy_b !== 1'b1) err++;
            if (m >= 8 && busy_b !== 1'b0) err++;
            if (done_b === 1'b1) begin
                ndone++;
                done_at = m;
            end
        end
        cs = cs_b;
    endtask

    initial begin
        logic [15:0] cs;
        int          nd, at, err;

        Reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        seed    = 16'h0000;
        repeat (3) @(negedge Clock);
        chk("rst_addr", 32'(addr_b), 32'(B_BASE));
        chk("rst_addr_a", 32'(addr_a), 32'(A_BASE));
        chk("rst_busy", 32'(busy_b), 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        chk("rst_crc", 32'(cs_b), 32'hFFFF);
        chk("rst_wc", 32'(wc_b), 32'd0);
        chk("rst_we", 32'(we_b), 32'd1);
        Reset = 1'b0;

        // single zero word: checksum 1D0F, done four cycles after the start edge
        @(negedge Clock);
        start_a = 1'b1;
        nd = 0;
        at = -1;
        for (int m = 1; m <= 8; m++) begin
            @(negedge Clock);
            start_a = 1'b0;
            if (m == 1) chk("a_addr", 32'(addr_a), 32'(A_BASE));
            if (done_a === 1'b1) begin
                nd++;
                at = m;
            end
        end
        chk("a_done_at", 32'(at), 32'd4);
        chk("a_ndone", 32'(nd), 32'd1);
        chk("a_crc", 32'(cs_a), 32'h1D0F);
        chk("a_wc", 32'(wc_a), 32'd1);

        // four zero words across the address wrap
        run_b(0, 0, cs, nd, at, err);
        chk("b0_seq", 32'(err), 32'd0);
        chk("b0_ndone", 32'(nd), 32'd1);
        chk("b0_done_at", 32'(at), 32'd8);
        chk("b0_crc", 32'(cs), 32'(exp_b(16'h0000)));
        chk("b0_wc", 32'(wc_b), 32'd4);

        // non-zero data, start pulsed mid-run and during the done cycle
        seed = 16'hA5C3;
        run_b(3, 8, cs, nd, at, err);
        chk("b1_seq", 32'(err), 32'd0);
        chk("b1_ndone", 32'(nd), 32'd1);
        chk("b1_done_at", 32'(at), 32'd8);
        chk("b1_crc", 32'(cs), 32'(exp_b(16'hA5C3)));
        chk("b1_wc", 32'(wc_b), 32'd4);
        repeat (4) @(negedge Clock);
        chk("b1_hold_crc", 32'(cs_b), 32'(exp_b(16'hA5C3)));
        chk("b1_hold_busy", 32'(busy_b), 32'd0);

        // reset in the middle of issue (start asserted with it), reads still in flight
        seed = 16'h5A3C;
        @(negedge Clock);
        start_b = 1'b1;
        @(negedge Clock);
        start_b = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset   = 1'b1;
        start_b = 1'b1;
        @(negedge Clock);
        Reset   = 1'b0;
        start_b = 1'b0;
        chk("mr_busy", 32'(busy_b), 32'd0);
        chk("mr_done", 32'(done_b), 32'd0);
        chk("mr_addr", 32'(addr_b), 32'(B_BASE));
        chk("mr_crc", 32'(cs_b), 32'hFFFF);
        chk("mr_wc", 32'(wc_b), 32'd0);
        repeat (5) @(negedge Clock);
        chk("mr_late_wc", 32'(wc_b), 32'd0);
        chk("mr_late_crc", 32'(cs_b), 32'hFFFF);
        chk("mr_late_busy", 32'(busy_b), 32'd0);

        run_b(0, 0, cs, nd, at, err);
        chk("b2_seq", 32'(err), 32'd0);
        chk("b2_ndone", 32'(nd), 32'd1);
        chk("b2_crc", 32'(cs), 32'(exp_b(16'h5A3C)));
        chk("b2_wc", 32'(wc_b), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
